// File: rtl/gene_net_attractor_if.sv
// -----------------------------------------------------------------------------
// gene_net_attractor_if
// Bundles the trajectory stream input and the attractor result outputs of
// gene_net_attractor.
//   master : producer/observer side (drives start/state_vld/state_in)
//   slave  : the analyser (drives busy/done/ovf and the result fields)
// DEPTH must match the DEPTH of the attached gene_net_attractor.
// -----------------------------------------------------------------------------
interface gene_net_attractor_if #(
    parameter int DEPTH = 32
);
    localparam int LW = $clog2(DEPTH + 1);

    logic          start;
    logic          state_vld;
    logic [7:0]    state_in;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [LW-1:0] transient_len;
    logic [LW-1:0] cycle_len;
    logic [7:0]    cyc_state;

    modport master (
        output start, state_vld, state_in,
        input  busy, done, ovf, transient_len, cycle_len, cyc_state
    );

    modport slave (
        input  start, state_vld, state_in,
        output busy, done, ovf, transient_len, cycle_len, cyc_state
    );
endinterface

// File: rtl/gene_net_attractor.sv
// -----------------------------------------------------------------------------
// gene_net_attractor
// Watches the state stream of the 8-gene Boolean network and reports the first
// revisited state: transient length (index of its first occurrence), cycle
// length (attractor period) and the cycle-entry state. If DEPTH distinct states
// arrive without a repeat, the next non-matching sample raises ovf.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : gene_net_attractor_if.slave
//            start, state_vld, state_in           (in)
//            busy, done, ovf, transient_len,
//            cycle_len, cyc_state                 (out)
// -----------------------------------------------------------------------------
module gene_net_attractor #(
    parameter int DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gene_net_attractor_if.slave  bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

    state_t        state_q;
    logic [LW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          ovf_q;
    logic [LW-1:0] tl_q;
    logic [LW-1:0] cl_q;
    logic [7:0]    cs_q;
    logic [7:0]    hist_q [DEPTH];

    logic          hit;
    logic [LW-1:0] hit_idx;
    logic          full;
    logic          accept;
    logic          wr_en;

    // Parallel compare against the valid part of the history. Entries are
    // distinct, so at most one index can hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((LW'(i) < cnt_q) && (hist_q[i] == bus.state_in)) begin
                hit     = 1'b1;
                hit_idx = LW'(i);
            end
        end
    end

    assign full   = (cnt_q == LW'(DEPTH));
    // start wins over a same-cycle sample, which is then dropped.
    assign accept = (state_q == TRACK) && bus.state_vld && !bus.start;
    assign wr_en  = accept && !hit && !full;

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tl_q    <= '0;
            cl_q    <= '0;
            cs_q    <= '0;
        end else if (bus.start) begin
            state_q <= TRACK;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tl_q    <= '0;
            cl_q    <= '0;
            cs_q    <= '0;
        end else if (accept) begin
            if (hit) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                tl_q    <= hit_idx;
                cl_q    <= cnt_q - hit_idx;
                cs_q    <= bus.state_in;
            end else if (full) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                ovf_q   <= 1'b1;
                tl_q    <= LW'(DEPTH);
                cl_q    <= '0;
                cs_q    <= bus.state_in;
            end else begin
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

    // History storage; contents beyond cnt_q are never looked at, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            hist_q[cnt_q[AW-1:0]] <= bus.state_in;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.ovf           = ovf_q;
    assign bus.transient_len = tl_q;
    assign bus.cycle_len     = cl_q;
    assign bus.cyc_state     = cs_q;
endmodule

// File: tb/tb_gene_net_attractor.sv
// -----------------------------------------------------------------------------
// tb_gene_net_attractor
// Two analysers (DEPTH=32 and DEPTH=4) receive identical stimulus. Expected
// outputs come from a reference that scans the list of samples accepted since
// the last start for the first repeated value.
// -----------------------------------------------------------------------------
module tb_gene_net_attractor;
    logic clk;
    logic rst_n;

    gene_net_attractor_if #(.DEPTH(32)) b32 ();
    gene_net_attractor_if #(.DEPTH(4))  b4  ();

    gene_net_attractor #(.DEPTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    gene_net_attractor #(.DEPTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       ovf;
        logic [8:0] tl;
        logic [8:0] cl;
        logic [7:0] cs;
    } res_t;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic       started  = 1'b0;
    logic [7:0] seq[$];

    // Reference: result of the trajectory 'seq' for a given history depth.
    function automatic res_t model(input int depth);
        res_t r;
        r = '0;
        if (!started) return r;
        for (int t = 0; t < seq.size(); t++) begin
            for (int j = 0; j < t && j < depth; j++) begin
                if (seq[j] == seq[t]) begin
                    r.done = 1'b1;
                    r.tl   = 9'(j);
                    r.cl   = 9'(t - j);
                    r.cs   = seq[t];
                    return r;
                end
            end
            if (t == depth) begin
                r.done = 1'b1;
                r.ovf  = 1'b1;
                r.tl   = 9'(depth);
                r.cs   = seq[t];
                return r;
            end
        end
        r.busy = 1'b1;
        return r;
    endfunction

    function automatic res_t obs32();
        res_t r;
        r.busy = b32.busy;  r.done = b32.done;  r.ovf = b32.ovf;
        r.tl   = 9'(b32.transient_len);
        r.cl   = 9'(b32.cycle_len);
        r.cs   = b32.cyc_state;
        return r;
    endfunction

    function automatic res_t obs4();
        res_t r;
        r.busy = b4.busy;  r.done = b4.done;  r.ovf = b4.ovf;
        r.tl   = 9'(b4.transient_len);
        r.cl   = 9'(b4.cycle_len);
        r.cs   = b4.cyc_state;
        return r;
    endfunction

    // Drive one clock cycle of stimulus to both analysers; returns 1 ns after
    // the rising edge with inputs back to idle.
    task automatic cycle(input logic st, input logic v, input logic [7:0] d);
        b32.start = st;  b32.state_vld = v;  b32.state_in = d;
        b4.start  = st;  b4.state_vld  = v;  b4.state_in  = d;
        @(posedge clk);
        if (rst_n) begin
            if (st) begin
                started = 1'b1;
                seq.delete();
            end else if (started && v) begin
                seq.push_back(d);
            end
        end
        #1;
        b32.start = 1'b0;  b32.state_vld = 1'b0;  b32.state_in = 8'h00;
        b4.start  = 1'b0;  b4.state_vld  = 1'b0;  b4.state_in  = 8'h00;
    endtask

    task automatic feed(input logic [7:0] vals[$]);
        foreach (vals[i]) cycle(1'b0, 1'b1, vals[i]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b32.start = 0; b32.state_vld = 0; b32.state_in = 0;
        b4.start  = 0; b4.state_vld  = 0; b4.state_in  = 0;
        repeat (2) @(posedge clk);
        #2;
        n_assert++;
        if (obs32() !== res_t'(0)) begin n_fail++; $display("FAIL reset32 got %h want 0", obs32()); end
        n_assert++;
        if (obs4() !== res_t'(0)) begin n_fail++; $display("FAIL reset4 got %h want 0", obs4()); end
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 8'h12);  // ignored in IDLE
        n_assert++;
        if (obs32() !== res_t'(0)) begin n_fail++; $display("FAIL idle_ignore got %h want 0", obs32()); end
    endtask

    task automatic test_trajectory();
        cycle(1'b1, 1'b0, 8'h00);
        n_assert++;
        if (b32.busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise got %b want 1", b32.busy); end
        feed('{8'h80, 8'h04, 8'h20, 8'h02, 8'h58, 8'h93, 8'h1C, 8'hB2, 8'h1C});
        n_assert++;
        if ({b32.done, b32.ovf, b32.transient_len, b32.cycle_len, b32.cyc_state} !== {1'b1, 1'b0, 6'd6, 6'd2, 8'h1C}) begin
            n_fail++;
            $display("FAIL traj32 got done=%b ovf=%b tl=%0d cl=%0d cs=%h want 1 0 6 2 1c",
                     b32.done, b32.ovf, b32.transient_len, b32.cycle_len, b32.cyc_state);
        end
        n_assert++;
        if (obs4() !== model(4)) begin n_fail++; $display("FAIL traj4 got %h want %h", obs4(), model(4)); end
    endtask

    task automatic test_fixed_point();
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        n_assert++;
        if (b32.done !== 1'b0) begin n_fail++; $display("FAIL fp_early got done=%b want 0", b32.done); end
        cycle(1'b0, 1'b1, 8'h00);
        n_assert++;
        if ({b32.done, b32.ovf, b32.transient_len, b32.cycle_len, b32.cyc_state} !== {1'b1, 1'b0, 6'd0, 6'd1, 8'h00}) begin
            n_fail++;
            $display("FAIL fixed_point got done=%b tl=%0d cl=%0d cs=%h want 1 0 1 00",
                     b32.done, b32.transient_len, b32.cycle_len, b32.cyc_state);
        end
    endtask

    task automatic test_overflow();
        cycle(1'b1, 1'b0, 8'h00);
        feed('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        n_assert++;
        if ({b4.done, b4.ovf, b4.transient_len, b4.cycle_len, b4.cyc_state} !== {1'b1, 1'b1, 3'd4, 3'd0, 8'h05}) begin
            n_fail++;
            $display("FAIL ovf4 got done=%b ovf=%b tl=%0d cl=%0d cs=%h want 1 1 4 0 05",
                     b4.done, b4.ovf, b4.transient_len, b4.cycle_len, b4.cyc_state);
        end
        n_assert++;
        if (obs32() !== model(32)) begin n_fail++; $display("FAIL ovf32_busy got %h want %h", obs32(), model(32)); end
        cycle(1'b1, 1'b0, 8'h00);
        feed('{8'h01, 8'h02, 8'h03, 8'h04, 8'h02});
        n_assert++;
        if ({b4.done, b4.ovf, b4.transient_len, b4.cycle_len} !== {1'b1, 1'b0, 3'd1, 3'd3}) begin
            n_fail++;
            $display("FAIL full_match4 got done=%b ovf=%b tl=%0d cl=%0d want 1 0 1 3",
                     b4.done, b4.ovf, b4.transient_len, b4.cycle_len);
        end
    endtask

    task automatic test_gapped();
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        repeat (3) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        n_assert++;
        if ({b32.done, b32.transient_len, b32.cycle_len, b32.cyc_state} !== {1'b1, 6'd0, 6'd1, 8'h00}) begin
            n_fail++;
            $display("FAIL gapped got done=%b tl=%0d cl=%0d cs=%h want 1 0 1 00",
                     b32.done, b32.transient_len, b32.cycle_len, b32.cyc_state);
        end
        feed('{8'h55, 8'h66, 8'h55});
        n_assert++;
        if ({b32.done, b32.ovf, b32.transient_len, b32.cycle_len, b32.cyc_state} !== {1'b1, 1'b0, 6'd0, 6'd1, 8'h00}) begin
            n_fail++;
            $display("FAIL done_hold got done=%b tl=%0d cl=%0d cs=%h want 1 0 1 00",
                     b32.done, b32.transient_len, b32.cycle_len, b32.cyc_state);
        end
    endtask

    task automatic test_restart();
        cycle(1'b1, 1'b0, 8'h00);
        feed('{8'h11, 8'h22});
        cycle(1'b1, 1'b1, 8'h11);
        feed('{8'h33, 8'h44, 8'h33});
        n_assert++;
        if ({b32.done, b32.ovf, b32.transient_len, b32.cycle_len, b32.cyc_state} !== {1'b1, 1'b0, 6'd0, 6'd2, 8'h33}) begin
            n_fail++;
            $display("FAIL restart got done=%b tl=%0d cl=%0d cs=%h want 1 0 2 33",
                     b32.done, b32.transient_len, b32.cycle_len, b32.cyc_state);
        end
        n_assert++;
        if (obs4() !== model(4)) begin n_fail++; $display("FAIL restart4 got %h want %h", obs4(), model(4)); end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 1'b0, 8'h00);
        feed('{8'hA1, 8'hA2});
        #3;
        rst_n   = 1'b0;
        started = 1'b0;
        seq.delete();
        #1;
        n_assert++;
        if (obs32() !== res_t'(0)) begin n_fail++; $display("FAIL async_rst32 got %h want 0", obs32()); end
        n_assert++;
        if (obs4() !== res_t'(0)) begin n_fail++; $display("FAIL async_rst4 got %h want 0", obs4()); end
        @(negedge clk);
        rst_n = 1'b1;
        feed('{8'hA1, 8'hA1, 8'hA1});
        n_assert++;
        if (obs32() !== res_t'(0)) begin n_fail++; $display("FAIL post_rst_idle got %h want 0", obs32()); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 24; r++) begin
            int span;
            span = (r % 3 == 0) ? 255 : ((r % 3 == 1) ? 15 : 63);
            cycle(1'b1, 1'b0, 8'h00);
            for (int c = 0; c < 45; c++) begin
                cycle(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom_range(0, span)));
                n_assert++;
                if (obs32() !== model(32)) begin
                    n_fail++;
                    $display("FAIL rand32 r=%0d c=%0d got %h want %h", r, c, obs32(), model(32));
                end
                n_assert++;
                if (obs4() !== model(4)) begin
                    n_fail++;
                    $display("FAIL rand4 r=%0d c=%0d got %h want %h", r, c, obs4(), model(4));
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_trajectory();
        test_fixed_point();
        test_overflow();
        test_gapped();
        test_restart();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
